// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative MIPS MULT/MULTU unit: state encodings,
// funct codes and default sizing.
package mult_unit_pkg;

  localparam int MU_N     = 32;
  localparam int MU_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mu_state_e;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  // Magnitude of an operand: negate only when it is a negative signed value.
  function automatic logic [MU_N-1:0] mu_abs(input logic [MU_N-1:0] x, input logic sgn);
    logic [MU_N-1:0] r;
    if (sgn && x[MU_N-1]) begin
      r = ~x + {{(MU_N-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_unit_rc_adder.sv
// Parameterised ripple-carry adder used for the partial-product accumulation.
module rc_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[N];

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle 32x32 shift-add multiplier for MULT/MULTU; one add per RUN cycle,
// sign fix-up in a final FIX cycle, result held in hi/lo until the next FIX.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int N     = MU_N,
  parameter int CNT_W = MU_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  mu_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;

  logic [N-1:0]     addend_s;
  logic [N-1:0]     sum_s;
  logic             cout_s;
  logic [2*N-1:0]   prod_s;

  assign addend_s = p_q[0] ? mcand_q : {N{1'b0}};

  rc_adder #(.N(N)) u_acc (
    .a    (p_q[2*N-1:N]),
    .b    (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign prod_s = neg_q ? (~p_q + {{(2*N-1){1'b0}}, 1'b1}) : p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = mu_abs(a, is_signed);
          p_d     = {{N{1'b0}}, mu_abs(b, is_signed)};
          neg_d   = is_signed & (a[N-1] ^ b[N-1]);
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // Carry out of the add becomes the new MSB as the product shifts right.
        p_d   = {cout_s, sum_s, p_q[N-1:1]};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(N-1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        hi_d    = prod_s[2*N-1:N];
        lo_d    = prod_s[N-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      mcand_q <= {N{1'b0}};
      p_q     <= {(2*N){1'b0}};
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= {N{1'b0}};
      lo_q    <= {N{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: 64-bit arithmetic reference, cycle-exact
// done/busy timing, hold of hi/lo, busy-start rejection and mid-op reset.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          bf = 1;
  int          bt = 0;
  logic [63:0] last_prod = 64'd0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Monitor: busy window, done/busy exclusion, scoreboard pop, hi/lo hold.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    exp_busy = (cyc >= bf) && (cyc <= bt);
    n_tests++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, exp_busy);
    end
    if (done === 1'b1) begin
      n_tests++;
      if (busy === 1'b1) begin
        n_fail++;
        $display("FAIL done_with_busy cyc=%0d", cyc);
      end
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h", cyc, hi, lo);
      end else begin
        e = sb.pop_front();
        if ({hi, lo} !== e.prod || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL result cyc=%0d got %h_%h exp %h at cyc %0d", cyc, hi, lo, e.prod, e.cyc);
        end
        last_prod = e.prod;
      end
    end else begin
      n_tests++;
      if ({hi, lo} !== last_prod) begin
        n_fail++;
        $display("FAIL hold cyc=%0d got %h_%h exp %h", cyc, hi, lo, last_prod);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; the bench's own busy window decides acceptance.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    start = 1'b1; a = x; b = y; is_signed = s;
    if (!((cyc >= bf) && (cyc <= bt))) begin
      e.prod = ref_mul(x, y, s);
      e.cyc  = cyc + 34;
      sb.push_back(e);
      bf = cyc + 1;
      bt = cyc + 33;
    end
    tick();
    start = 1'b0;
    a = $urandom(); b = $urandom(); is_signed = 1'($urandom());
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
      sb.delete();
    end
    tick();
  endtask

  initial begin
    int t;
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0000_FFFF;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    issue(32'd6, 32'd7, 1'b0);
    drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();
    issue(-32'sd3, 32'd5, 1'b1);
    drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    drain();

    // Start while busy is ignored; start in the done cycle is accepted.
    t = cyc;
    issue(32'd1234, 32'd5678, 1'b0);
    wait_until(t + 5);
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    wait_until(t + 34);
    issue(32'hFFFF_FFF0, 32'd3, 1'b1);
    drain();

    // Reset mid-operation aborts with no done and clears hi/lo.
    t = cyc;
    issue(32'd99, 32'd77, 1'b0);
    wait_until(t + 10);
    reset = 1'b1;
    sb.delete();
    bf = 1; bt = 0;
    last_prod = 64'd0;
    tick();
    reset = 1'b0;
    tick(); tick();
    issue(32'd2, 32'd3, 1'b0);
    drain();

    // Random back-to-back operations, each issued in the previous done cycle.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      if (bt >= cyc) wait_until(bt + 1);
      issue(x, y, 1'($urandom()));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
